// File: rtl/stream_pkg.sv
// Shared types for the stream buffer fill path: line address/data shapes and
// the prefetcher state encoding.
package stream_pkg;

  localparam int unsigned ADDR_WIDTH         = 32;
  localparam int unsigned DATA_WIDTH         = 32;
  localparam int unsigned BLOCK_OFFSET_WIDTH = 2;
  localparam int unsigned WORDS_PER_LINE     = 1 << BLOCK_OFFSET_WIDTH;
  localparam int unsigned LINE_ADDR_WIDTH    = ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2;
  localparam int unsigned LINE_DATA_WIDTH    = DATA_WIDTH * WORDS_PER_LINE;

  typedef logic [LINE_ADDR_WIDTH-1:0] line_addr_t;
  typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_data_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DRAIN
  } pf_state_e;

  // Sequential line successor; wraps modulo the line address space.
  function automatic line_addr_t next_line(input line_addr_t a);
    return a + LINE_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/stream_prefetcher.sv
// Stream buffer fill engine: on a demand miss, fetches the following
// PREFETCH_DEPTH lines one at a time and writes each into the stream buffer.
module stream_prefetcher
  import stream_pkg::*;
#(
  parameter int unsigned PREFETCH_DEPTH = 4,
  parameter int unsigned CNT_WIDTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] i_miss_addr,
  output logic                       o_mem_req_valid,
  input  logic                       i_mem_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                       i_mem_resp_valid,
  input  logic [LINE_DATA_WIDTH-1:0] i_mem_resp_data,
  output logic                       o_we,
  output logic [LINE_ADDR_WIDTH-1:0] o_waddr,
  output logic [LINE_DATA_WIDTH-1:0] o_wdata,
  output logic                       o_busy
);

  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(PREFETCH_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  pf_state_e            state, state_n;
  line_addr_t           next_addr, next_addr_n;
  logic [CNT_WIDTH-1:0] remaining, remaining_n;
  line_data_t           wdata_n;

  // Next-state and datapath; next_addr doubles as the pending restart address in DRAIN.
  always_comb begin
    state_n     = state;
    next_addr_n = next_addr;
    remaining_n = remaining;
    wdata_n     = o_wdata;

    if (i_miss_valid) begin
      next_addr_n = next_line(i_miss_addr);
      remaining_n = DEPTH;
    end

    unique case (state)
      IDLE: begin
        if (i_miss_valid) state_n = REQ;
      end
      REQ: begin
        if (i_mem_req_ready) state_n = i_miss_valid ? DRAIN : WAIT;
      end
      WAIT: begin
        if (i_miss_valid) begin
          state_n = i_mem_resp_valid ? REQ : DRAIN;
        end else if (i_mem_resp_valid) begin
          wdata_n = i_mem_resp_data;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (i_miss_valid) begin
          state_n = REQ;
        end else begin
          next_addr_n = next_line(next_addr);
          remaining_n = remaining - ONE;
          state_n     = (remaining == ONE) ? IDLE : REQ;
        end
      end
      DRAIN: begin
        if (i_mem_resp_valid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      next_addr       <= '0;
      remaining       <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_addr  <= '0;
      o_we            <= 1'b0;
      o_waddr         <= '0;
      o_wdata         <= '0;
      o_busy          <= 1'b0;
    end else begin
      state           <= state_n;
      next_addr       <= next_addr_n;
      remaining       <= remaining_n;
      o_mem_req_valid <= (state_n == REQ);
      o_mem_req_addr  <= next_addr_n;
      o_we            <= (state_n == WRITE);
      if (state_n == WRITE) o_waddr <= next_addr_n;
      o_wdata         <= wdata_n;
      o_busy          <= (state_n != IDLE);
    end
  end

  // A response with no request outstanding means the memory side broke protocol.
  resp_protocol_a: assert property (@(posedge clk) disable iff (rst)
    i_mem_resp_valid |-> (state != IDLE && state != REQ))
    else $error("stream_prefetcher: memory response with no request outstanding");

endmodule

// File: doc/stream_prefetcher.md
Name: stream_prefetcher

Overview:
- Fill engine for the fully-associative stream buffer: the writer side of that buffer's `i_we`/`i_waddr`/`i_wdata` port.
- On a data-cache miss it fetches the next PREFETCH_DEPTH sequential cache lines from memory, one request outstanding at a time.
- It writes each returned line into the stream buffer.
- It sits between the cache-miss logic, the memory read port and the stream buffer write port.

Parameters:
- BLOCK_OFFSET_WIDTH, 2: log2 of words per line; line address is [`ADDR_WIDTH-1 : BLOCK_OFFSET_WIDTH+2].
- PREFETCH_DEPTH, 4: lines fetched per stream (1..15).
- CNT_WIDTH, 4: width of the remaining-line counter; must hold PREFETCH_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_miss_valid  in  1  one-cycle pulse: demand miss occurred.
- i_miss_addr  in  `ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2  line address of the miss.
- o_mem_req_valid  out  1  memory read request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_addr  out  `ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2  requested line address.
- i_mem_resp_valid  in  1  response data valid, one cycle per request.
- i_mem_resp_data  in  `DATA_WIDTH x (1<<BLOCK_OFFSET_WIDTH)  returned line.
- o_we  out  1  stream buffer write enable.
- o_waddr  out  `ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2  line address written.
- o_wdata  out  `DATA_WIDTH x (1<<BLOCK_OFFSET_WIDTH)  line written.
- o_busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered. Reset, asserted asynchronously at any time (including mid-stream):
  - state=IDLE; all valids, o_we and o_busy are 0.
  - Addresses, data and counters are 0.
  - Any in-flight memory response is forgotten.
- States: IDLE, REQ, WAIT, WRITE, DRAIN.
- IDLE: on i_miss_valid, next_addr <= i_miss_addr+1 and remaining <= PREFETCH_DEPTH; go to REQ. o_mem_req_valid rises the cycle after the miss pulse.
- REQ:
  - o_mem_req_valid=1 and o_mem_req_addr=next_addr, both held stable until i_mem_req_ready=1.
  - On handshake go to WAIT; o_mem_req_valid drops the following cycle.
- WAIT: on i_mem_resp_valid, capture i_mem_resp_data into o_wdata and go to WRITE.
- WRITE:
  - o_we=1 for exactly one cycle, with o_waddr = address of the fetched line and o_wdata = the response from the previous cycle.
  - Then next_addr++ and remaining--.
  - remaining reaching 0 goes to IDLE; otherwise go to REQ.
- Latency: response at cycle t gives o_we at t+1, and the next request at t+2.
- Address arithmetic: line-address increment wraps modulo 2^(`ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2). All-ones + 1 = 0.
- New miss (i_miss_valid) while not IDLE restarts the stream with next_addr=i_miss_addr+1 and remaining=PREFETCH_DEPTH:
  - in REQ without handshake: request address changes the next cycle (a retarget while unaccepted is permitted); stay in REQ.
  - in REQ with handshake the same cycle: request is in flight; go to DRAIN holding the new address.
  - in WAIT: go to DRAIN.
  - in WRITE: the current o_we still fires; then go to REQ with the new address.
  - in DRAIN: the pending address is overwritten with the newer miss (last miss wins).
- DRAIN: wait for i_mem_resp_valid and discard that data (no o_we), then go to REQ with the pending address.
- Miss and response in the same cycle in WAIT: the response is discarded and the block goes directly to REQ with the new address (no DRAIN).
- i_mem_resp_valid in IDLE or REQ is a protocol violation: ignored, and flagged by a simulation assertion.
- Duplicate-line filtering is not done here; the stream buffer drops writes to lines already present.

Decomposition:
- Shared package (mips_core_pkg or a new stream_pkg):
  - typedef line_addr_t (`ADDR_WIDTH-BLOCK_OFFSET_WIDTH-2 bits).
  - typedef line_data_t (array of `DATA_WIDTH words).
  - enum pf_state_e {IDLE, REQ, WAIT, WRITE, DRAIN}.
- Single module; no sub-module. The restart/pending-address latch is small enough to stay inline.

Test Plan:
- Basic stream (PREFETCH_DEPTH=4): miss 0x0000100 with ready=1 and response 3 cycles after each accept:
  - requests are 0x101, 0x102, 0x103, 0x104, in order.
  - four o_we pulses with matching o_waddr/o_wdata.
  - o_busy falls after the 4th write.
- Backpressure: hold i_mem_req_ready=0 for 5 cycles:
  - o_mem_req_valid=1 with o_mem_req_addr=0x101 stable throughout.
  - exactly one accept when ready rises.
- Restart in WAIT: miss 0x200, then miss 0x500 while waiting for the 0x201 response:
  - 0x201 data is dropped (no o_we).
  - next requests are 0x501..0x504.
- Restart in WRITE: second miss 0x800 during the o_we cycle for 0x102:
  - 0x102 is written.
  - the next request is 0x801.
- Wrap-around: miss at line address all-ones: requests are 0x0000000, 0x0000001, 0x0000002, 0x0000003.
- Asynchronous reset asserted mid-WAIT, between clock edges:
  - o_mem_req_valid, o_we and o_busy go to 0 immediately.
  - a late response after reset produces no o_we.
